// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, constants and helpers for the calculator sequencer
// Purpose: sequencer state encoding, ALU op-code encoding, operand width,
//          largest displayable value and small BCD helper functions.
// Ports:   none (package).
package calc_pkg;

   localparam int OPW       = 14;
   localparam int MAX_VALUE = 9999;

   typedef enum logic [2:0] {
      ENTER_A,
      ENTER_B,
      EXEC,
      WAIT,
      CONVERT,
      SHOW,
      ERROR
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   // Digit increment without carry into the next digit.
   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   // Double-dabble correction step for one BCD digit.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // Four BCD digits (thousands in [15:12]) to binary; 9999 fits in OPW bits.
   function automatic logic [OPW-1:0] bcd_to_bin(input logic [15:0] d);
      return OPW'(d[15:12]) * OPW'(1000) + OPW'(d[11:8]) * OPW'(100)
           + OPW'(d[7:4]) * OPW'(10) + OPW'(d[3:0]);
   endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// rtl/calc_bin2bcd.sv - iterative shift-add-3 binary to BCD converter
// Purpose: converts a 0..9999 binary value to four BCD digits, one bit per cycle.
//          o_done is high during the 14th cycle after i_start and o_bcd is
//          valid in that same cycle.
// Ports:   clk_in, reset (async, active low), i_start/i_bin (load request and
//          value), o_done/o_bcd (result strobe and digits, thousands in [15:12]).
module calc_bin2bcd
   import calc_pkg::*;
(
   input  logic           clk_in,
   input  logic           reset,
   input  logic           i_start,
   input  logic [OPW-1:0] i_bin,
   output logic           o_done,
   output logic [15:0]    o_bcd
);

   // Only 15 BCD bits are stored: every partial value is at most 4999, so the
   // thousands digit stays below 5 (no correction, never needs bit 15) until
   // the final step, which is presented combinationally and not stored.
   logic [14:0]    r_bcd;
   logic [OPW-1:0] r_bin;
   logic [3:0]     r_cnt;
   logic           r_busy;
   logic [11:0]    w_adj;

   assign w_adj  = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
   assign o_bcd  = {r_bcd[14:12], w_adj, r_bin[OPW-1]};
   assign o_done = r_busy && (r_cnt == 4'(OPW - 1));

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_bcd  <= '0;
         r_bin  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_bcd  <= '0;
         r_bin  <= i_bin;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (o_done) begin
            r_busy <= 1'b0;
         end else begin
            r_bcd <= o_bcd[14:0];
            r_bin <= {r_bin[OPW-2:0], 1'b0};
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - four-digit button calculator sequencer driving an external ALU
// Purpose: debounced-edge button decode, operand entry in BCD, ALU handshake
//          with timeout, result conversion to BCD and error display.
// Ports:   clk_in/reset (async, active low); btn_in[8:0] raw buttons
//          (0..3 digit increment, 4..7 add/sub/mul/div, 8 equals/clear);
//          alu_start/alu_op/alu_a/alu_b to the ALU; alu_done/alu_result/
//          alu_neg/alu_err from the ALU; digit1..digit4 display (ones first);
//          busy/err/neg status.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int ALU_TIMEOUT = 64,
   parameter int SYNC_STAGES = 2
)
(
   input  logic           clk_in,
   input  logic           reset,
   input  logic [8:0]     btn_in,
   output logic           alu_start,
   output logic [1:0]     alu_op,
   output logic [OPW-1:0] alu_a,
   output logic [OPW-1:0] alu_b,
   input  logic           alu_done,
   input  logic [OPW-1:0] alu_result,
   input  logic           alu_neg,
   input  logic           alu_err,
   output logic [3:0]     digit1,
   output logic [3:0]     digit2,
   output logic [3:0]     digit3,
   output logic [3:0]     digit4,
   output logic           busy,
   output logic           err,
   output logic           neg
);

   localparam int TW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

   logic [SYNC_STAGES-1:0][8:0] r_sync;
   logic [8:0]                  r_btn_prev;
   state_t                      r_state, w_state_nxt;
   logic [3:0][3:0]             r_dig, w_dig_nxt, w_dig_inc;
   op_t                         r_op, w_op_nxt;
   logic [OPW-1:0]              r_a, w_a_nxt, r_b, w_b_nxt;
   logic                        r_neg, w_neg_nxt;
   logic [TW-1:0]               r_tmo, w_tmo_nxt;

   logic [8:0]  w_rise;
   logic        w_evt_valid;
   logic [3:0]  w_evt_idx;
   logic        w_is_dig, w_is_op, w_is_eq;
   logic [1:0]  w_dig_sel;
   op_t         w_evt_op;
   logic        w_conv_start, w_conv_done;
   logic [15:0] w_conv_bcd;

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_btn_prev;

   // Descending scan so the lowest-numbered button wins a same-cycle tie.
   always_comb begin
      w_evt_valid = 1'b0;
      w_evt_idx   = 4'd0;
      for (int i = 8; i >= 0; i--) begin
         if (w_rise[i]) begin
            w_evt_valid = 1'b1;
            w_evt_idx   = 4'(i);
         end
      end
   end

   assign w_is_dig  = w_evt_valid && (w_evt_idx < 4'd4);
   assign w_is_op   = w_evt_valid && (w_evt_idx >= 4'd4) && (w_evt_idx < 4'd8);
   assign w_is_eq   = w_evt_valid && (w_evt_idx == 4'd8);
   assign w_dig_sel = w_evt_idx[1:0];
   assign w_evt_op  = op_t'(w_evt_idx[1:0]);

   calc_bin2bcd u_bin2bcd (
      .clk_in  (clk_in),
      .reset   (reset),
      .i_start (w_conv_start),
      .i_bin   (alu_result),
      .o_done  (w_conv_done),
      .o_bcd   (w_conv_bcd)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_dig_nxt    = r_dig;
      w_op_nxt     = r_op;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_neg_nxt    = r_neg;
      w_tmo_nxt    = r_tmo;
      w_conv_start = 1'b0;
      w_dig_inc    = r_dig;
      w_dig_inc[w_dig_sel] = bcd_inc(r_dig[w_dig_sel]);

      case (r_state)
         ENTER_A: begin
            if (w_is_dig) begin
               w_dig_nxt = w_dig_inc;
            end else if (w_is_op) begin
               w_op_nxt    = w_evt_op;
               w_a_nxt     = bcd_to_bin(r_dig);
               w_dig_nxt   = '0;
               w_state_nxt = ENTER_B;
            end
         end
         ENTER_B: begin
            if (w_is_dig) begin
               w_dig_nxt = w_dig_inc;
            end else if (w_is_op) begin
               w_op_nxt = w_evt_op;
            end else if (w_is_eq) begin
               w_b_nxt     = bcd_to_bin(r_dig);
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            w_tmo_nxt   = '0;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (alu_done) begin
               if (alu_err || (alu_result > OPW'(MAX_VALUE))) begin
                  w_dig_nxt   = '0;
                  w_neg_nxt   = 1'b0;
                  w_state_nxt = ERROR;
               end else begin
                  w_neg_nxt    = alu_neg;
                  w_conv_start = 1'b1;
                  w_state_nxt  = CONVERT;
               end
            end else if (r_tmo == TW'(ALU_TIMEOUT - 1)) begin
               w_dig_nxt   = '0;
               w_neg_nxt   = 1'b0;
               w_state_nxt = ERROR;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         CONVERT: begin
            if (w_conv_done) begin
               w_dig_nxt   = w_conv_bcd;
               w_state_nxt = SHOW;
            end
         end
         SHOW: begin
            if (w_is_dig) begin
               // Fresh entry: cleared digits plus the pressed increment.
               w_dig_nxt            = '0;
               w_dig_nxt[w_dig_sel] = 4'd1;
               w_neg_nxt            = 1'b0;
               w_state_nxt          = ENTER_A;
            end else if (w_is_op) begin
               // Chain on the displayed magnitude.
               w_op_nxt    = w_evt_op;
               w_a_nxt     = bcd_to_bin(r_dig);
               w_neg_nxt   = 1'b0;
               w_dig_nxt   = '0;
               w_state_nxt = ENTER_B;
            end
         end
         ERROR: begin
            w_dig_nxt = '0;
            w_neg_nxt = 1'b0;
            if (w_is_eq) begin
               w_state_nxt = ENTER_A;
            end
         end
         default: w_state_nxt = ENTER_A;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_sync     <= '0;
         r_btn_prev <= '0;
         r_state    <= ENTER_A;
         r_dig      <= '0;
         r_op       <= OP_ADD;
         r_a        <= '0;
         r_b        <= '0;
         r_neg      <= 1'b0;
         r_tmo      <= '0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], btn_in};
         r_btn_prev <= r_sync[SYNC_STAGES-1];
         r_state    <= w_state_nxt;
         r_dig      <= w_dig_nxt;
         r_op       <= w_op_nxt;
         r_a        <= w_a_nxt;
         r_b        <= w_b_nxt;
         r_neg      <= w_neg_nxt;
         r_tmo      <= w_tmo_nxt;
      end
   end

   assign alu_start = (r_state == EXEC);
   assign alu_op    = r_op;
   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign busy      = (r_state == EXEC) || (r_state == WAIT) || (r_state == CONVERT);
   assign err       = (r_state == ERROR);
   assign neg       = r_neg;
   assign digit1    = r_dig[0];
   assign digit2    = r_dig[1];
   assign digit3    = r_dig[2];
   assign digit4    = r_dig[3];

endmodule
